// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - stack responder executing push/pop/call/return commands
module stack_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              CmdValid,
    input  logic [1:0]        Cmd,
    input  logic [DATA_W-1:0] WData,
    input  logic [DATA_W-1:0] RetAddr,
    input  logic              ClrErr,
    output logic              Ready,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] RData,
    output logic [DATA_W-1:0] RetOut,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow,
    output logic              Underflow
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic [1:0]        cmd_q;
    logic [DATA_W-1:0] word_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              full, empty, is_pop, in_exec;
    logic              do_write, do_read, push_ovf, pop_unf;
    logic [ADDR_W-1:0] wr_addr, top_addr;

    // Count reaches bit ADDR_W only at exactly DEPTH entries.
    assign full     = Count[ADDR_W];
    assign empty    = (Count == '0);
    assign is_pop   = cmd_q[0];
    assign in_exec  = (state == EXEC);
    assign wr_addr  = Count[ADDR_W-1:0];
    assign top_addr = wr_addr - ADDR_W'(1);
    assign do_write = in_exec && !is_pop && !full;
    assign do_read  = in_exec &&  is_pop && !empty;
    assign push_ovf = in_exec && !is_pop &&  full;
    assign pop_unf  = in_exec &&  is_pop &&  empty;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Ready     = 1'b0;
        Done      = 1'b0;
        Err       = 1'b0;
        case (state)
            IDLE: begin
                Ready = 1'b1;
                if (CmdValid) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                Done      = 1'b1;
                Err       = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cmd_q     <= '0;
            word_q    <= '0;
            err_q     <= 1'b0;
            Count     <= '0;
            RData     <= '0;
            RetOut    <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (state == IDLE && CmdValid) begin
                cmd_q  <= Cmd;
                word_q <= Cmd[1] ? RetAddr : WData;
            end
            if (in_exec) err_q <= push_ovf || pop_unf;
            if (do_write) Count <= Count + (ADDR_W+1)'(1);
            if (do_read) begin
                Count <= Count - (ADDR_W+1)'(1);
                if (cmd_q[1]) RetOut <= mem[top_addr];
                else          RData  <= mem[top_addr];
            end
            // A flag being set on this edge takes priority over a clear.
            if (push_ovf)    Overflow  <= 1'b1;
            else if (ClrErr) Overflow  <= 1'b0;
            if (pop_unf)     Underflow <= 1'b1;
            else if (ClrErr) Underflow <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_write) mem[wr_addr] <= word_q;
    end

endmodule
